// File: rtl/glb_pcfg_dma.sv
`default_nettype none
// ============================================================================
// Module   : glb_pcfg_dma
// Purpose  : Parallel-configuration DMA for a global buffer tile. A start
//            pulse latches a header (8-byte aligned start address and word
//            count). The engine then streams read requests to the GLB bank
//            and turns every returned 64-bit word into one CGRA configuration
//            write: the upper half is the address and the lower half is the data.
// Revision : 1.0 - initial release
// Option   : GLB_PCFG_DMA_ERR_EN - when defined, adds the sticky pcfg_err
//            output. It flags responses that arrive while idle or while no
//            response is outstanding.
// Ports    :
//   clk                 in   clock
//   reset               in   asynchronous active-high reset
//   pcfg_start_pulse    in   one-cycle start request (ignored while busy)
//   pcfg_start_addr     in   header start address, bits [2:0] forced to 0
//   pcfg_num_cfgs       in   header configuration count
//   pcfg_busy           out  high in ISSUE / DRAIN / DONE
//   pcfg_done_pulse     out  one-cycle completion pulse
//   rdrq_rd_en          out  read request enable
//   rdrq_rd_addr        out  read request address
//   rdrs_rd_data        in   read response word
//   rdrs_rd_data_valid  in   read response valid
//   pcfg_err            out  sticky error flag (GLB_PCFG_DMA_ERR_EN only)
//   cgra_cfg_wr_en      out  configuration write enable
//   cgra_cfg_rd_en      out  configuration read enable, always 0
//   cgra_cfg_addr       out  configuration address
//   cgra_cfg_data       out  configuration data
// ============================================================================
module glb_pcfg_dma #(
   parameter int GLB_ADDR_WIDTH      = 22,
   parameter int BANK_DATA_WIDTH     = 64,
   parameter int CGRA_CFG_ADDR_WIDTH = 32,
   parameter int CGRA_CFG_DATA_WIDTH = 32,
   parameter int MAX_NUM_CFGS_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           pcfg_start_pulse,
   input  logic [GLB_ADDR_WIDTH-1:0]      pcfg_start_addr,
   input  logic [MAX_NUM_CFGS_WIDTH-1:0]  pcfg_num_cfgs,
   output logic                           pcfg_busy,
   output logic                           pcfg_done_pulse,
   output logic                           rdrq_rd_en,
   output logic [GLB_ADDR_WIDTH-1:0]      rdrq_rd_addr,
   input  logic [BANK_DATA_WIDTH-1:0]     rdrs_rd_data,
   input  logic                           rdrs_rd_data_valid,
`ifdef GLB_PCFG_DMA_ERR_EN
   output logic                           pcfg_err,
`endif
   output logic                           cgra_cfg_wr_en,
   output logic                           cgra_cfg_rd_en,
   output logic [CGRA_CFG_ADDR_WIDTH-1:0] cgra_cfg_addr,
   output logic [CGRA_CFG_DATA_WIDTH-1:0] cgra_cfg_data
);

   localparam logic [GLB_ADDR_WIDTH-1:0] c_ALIGN_MASK =
      {{(GLB_ADDR_WIDTH-3){1'b1}}, 3'b000};
   localparam logic [GLB_ADDR_WIDTH-1:0] c_ADDR_STEP =
      {{(GLB_ADDR_WIDTH-4){1'b0}}, 4'b1000};
   localparam logic [MAX_NUM_CFGS_WIDTH-1:0] c_CNT_ONE =
      {{(MAX_NUM_CFGS_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [MAX_NUM_CFGS_WIDTH-1:0] c_CNT_ZERO = '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                           r_state;
   logic                             r_busy;
   logic                             r_done;
   logic                             r_rd_en;
   logic [GLB_ADDR_WIDTH-1:0]        r_rd_addr;
   logic [MAX_NUM_CFGS_WIDTH-1:0]    r_issue_cnt;   // requests still to issue after the current one
   logic [MAX_NUM_CFGS_WIDTH-1:0]    r_outst_cnt;   // responses not yet received
   logic                             r_wr_en;
   logic [CGRA_CFG_ADDR_WIDTH-1:0]   r_cfg_addr;
   logic [CGRA_CFG_DATA_WIDTH-1:0]   r_cfg_data;

   logic                             w_rsp_accept;
   logic                             w_outst_dec;
   logic [GLB_ADDR_WIDTH-1:0]        w_start_aligned;

   // Responses are only consumed while a transfer is active; idle ones are dropped.
   assign w_rsp_accept    = rdrs_rd_data_valid & r_busy;
   // Saturate so a stray response can never wrap the outstanding count.
   assign w_outst_dec     = w_rsp_accept & (r_outst_cnt != c_CNT_ZERO);
   assign w_start_aligned = pcfg_start_addr & c_ALIGN_MASK;

   // Control FSM with request issue and the outstanding-response counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_issue_cnt <= '0;
         r_outst_cnt <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_outst_dec) begin
            r_outst_cnt <= r_outst_cnt - c_CNT_ONE;
         end
         case (r_state)
            ST_IDLE: begin
               if (pcfg_start_pulse) begin
                  r_busy    <= 1'b1;
                  r_rd_addr <= w_start_aligned;
                  if (pcfg_num_cfgs == c_CNT_ZERO) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     // The first request goes out in the very next cycle.
                     r_state     <= ST_ISSUE;
                     r_rd_en     <= 1'b1;
                     r_issue_cnt <= pcfg_num_cfgs - c_CNT_ONE;
                     r_outst_cnt <= pcfg_num_cfgs;
                  end
               end
            end
            ST_ISSUE: begin
               if (r_issue_cnt == c_CNT_ZERO) begin
                  r_rd_en <= 1'b0;
                  r_state <= ST_DRAIN;
               end else begin
                  r_issue_cnt <= r_issue_cnt - c_CNT_ONE;
                  r_rd_addr   <= r_rd_addr + c_ADDR_STEP;   // wraps silently
               end
            end
            ST_DRAIN: begin
               if (r_outst_cnt == c_CNT_ZERO) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_rd_en <= 1'b0;
            end
         endcase
      end
   end

   // Response path: unpack each accepted word into a configuration write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_en    <= 1'b0;
         r_cfg_addr <= '0;
         r_cfg_data <= '0;
      end else begin
         r_wr_en <= w_rsp_accept;
         if (w_rsp_accept) begin
            r_cfg_addr <= rdrs_rd_data[CGRA_CFG_ADDR_WIDTH+CGRA_CFG_DATA_WIDTH-1:CGRA_CFG_DATA_WIDTH];
            r_cfg_data <= rdrs_rd_data[CGRA_CFG_DATA_WIDTH-1:0];
         end
      end
   end

`ifdef GLB_PCFG_DMA_ERR_EN
   logic r_err;

   // A fresh error in the same cycle as an accepted start takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (rdrs_rd_data_valid && (!r_busy || (r_outst_cnt == c_CNT_ZERO))) begin
         r_err <= 1'b1;
      end else if (pcfg_start_pulse && (r_state == ST_IDLE)) begin
         r_err <= 1'b0;
      end
   end

   assign pcfg_err = r_err;
`endif

   assign pcfg_busy       = r_busy;
   assign pcfg_done_pulse = r_done;
   assign rdrq_rd_en      = r_rd_en;
   assign rdrq_rd_addr    = r_rd_addr;
   assign cgra_cfg_wr_en  = r_wr_en;
   assign cgra_cfg_rd_en  = 1'b0;
   assign cgra_cfg_addr   = r_cfg_addr;
   assign cgra_cfg_data   = r_cfg_data;

endmodule
`default_nettype wire

// File: tb/tb_glb_pcfg_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_glb_pcfg_dma
// Purpose  : Self-checking bench for glb_pcfg_dma. A cycle-stepped bank model
//            answers read requests at a chosen fixed latency. Each transfer's
//            request addresses, write words and cycle positions are predicted
//            from the header using plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_glb_pcfg_dma;

   localparam int AW = 22;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 pcfg_start_pulse;
   logic [AW-1:0]        pcfg_start_addr;
   logic [15:0]          pcfg_num_cfgs;
   logic                 pcfg_busy;
   logic                 pcfg_done_pulse;
   logic                 rdrq_rd_en;
   logic [AW-1:0]        rdrq_rd_addr;
   logic [63:0]          rdrs_rd_data;
   logic                 rdrs_rd_data_valid;
   logic                 cgra_cfg_wr_en;
   logic                 cgra_cfg_rd_en;
   logic [31:0]          cgra_cfg_addr;
   logic [31:0]          cgra_cfg_data;
`ifdef GLB_PCFG_DMA_ERR_EN
   logic                 pcfg_err;
`endif

   always #5 clk = ~clk;

   glb_pcfg_dma dut (
      .clk                (clk),
      .reset              (reset),
      .pcfg_start_pulse   (pcfg_start_pulse),
      .pcfg_start_addr    (pcfg_start_addr),
      .pcfg_num_cfgs      (pcfg_num_cfgs),
      .pcfg_busy          (pcfg_busy),
      .pcfg_done_pulse    (pcfg_done_pulse),
      .rdrq_rd_en         (rdrq_rd_en),
      .rdrq_rd_addr       (rdrq_rd_addr),
      .rdrs_rd_data       (rdrs_rd_data),
      .rdrs_rd_data_valid (rdrs_rd_data_valid),
`ifdef GLB_PCFG_DMA_ERR_EN
      .pcfg_err           (pcfg_err),
`endif
      .cgra_cfg_wr_en     (cgra_cfg_wr_en),
      .cgra_cfg_rd_en     (cgra_cfg_rd_en),
      .cgra_cfg_addr      (cgra_cfg_addr),
      .cgra_cfg_data      (cgra_cfg_data)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int g_lat    = 2;

   typedef struct {
      int            due;
      logic [AW-1:0] addr;
   } pend_t;

   pend_t        pend[$];
   logic [63:0]  bank[logic [AW-1:0]];
   int           req_cyc[$];
   logic [AW-1:0] req_addr[$];
   int           wr_cyc[$];
   logic [63:0]  wr_word[$];
   int           done_cyc[$];
   int           busy_cnt;

   // Bank contents: fixed where preloaded, otherwise random on first touch.
   function automatic logic [63:0] bank_word(input logic [AW-1:0] a);
      if (!bank.exists(a)) bank[a] = {$urandom, $urandom};
      return bank[a];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      req_cyc.delete();
      req_addr.delete();
      wr_cyc.delete();
      wr_word.delete();
      done_cyc.delete();
      busy_cnt = 0;
   endtask

   // One clock: record what the DUT shows in the new cycle, then drive the
   // bank response (if one is due) and default the start pulse low.
   task automatic step();
      pend_t p;
      @(posedge clk);
      #1;
      cyc++;
      if (rdrq_rd_en === 1'b1) begin
         req_cyc.push_back(cyc);
         req_addr.push_back(rdrq_rd_addr);
         p.due  = cyc + g_lat;
         p.addr = rdrq_rd_addr;
         pend.push_back(p);
      end
      if (cgra_cfg_wr_en === 1'b1) begin
         wr_cyc.push_back(cyc);
         wr_word.push_back({cgra_cfg_addr, cgra_cfg_data});
      end
      if (pcfg_done_pulse === 1'b1) done_cyc.push_back(cyc);
      if (pcfg_busy === 1'b1) busy_cnt++;
      pcfg_start_pulse   = 1'b0;
      rdrs_rd_data_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         rdrs_rd_data_valid = 1'b1;
         rdrs_rd_data       = bank_word(pend[0].addr);
         void'(pend.pop_front());
      end
   endtask

   // Run one transfer and compare it against the header-derived prediction.
   // second_at > 0 injects an extra start (num 5) that many cycles after start.
   task automatic run_xfer(input logic [AW-1:0] a, input int n, input int lat,
                           input int second_at, input string tag);
      int            t0;
      int            exp_done;
      logic [AW-1:0] base;
      logic [AW-1:0] ea;
      g_lat = lat;
      clear_logs();
      pcfg_start_addr  = a;
      pcfg_num_cfgs    = 16'(n);
      pcfg_start_pulse = 1'b1;
      t0 = cyc;
      for (int k = 0; k < 400 && done_cyc.size() == 0; k++) begin
         step();
         if (second_at > 0 && cyc == t0 + second_at) begin
            pcfg_start_pulse = 1'b1;
            pcfg_num_cfgs    = 16'd5;
            pcfg_start_addr  = a + 22'h40;
         end
      end
      repeat (4) step();
      base = a & ~22'h7;
      exp_done = (n == 0) ? t0 + 1 : t0 + 2 + n + lat;
      chk({tag, " req_count"}, 64'(req_cyc.size()), 64'(n));
      for (int i = 0; i < n && i < req_cyc.size(); i++) begin
         ea = base + 22'(8 * i);
         chk({tag, " req_addr"}, 64'(req_addr[i]), 64'(ea));
         chk({tag, " req_cycle"}, 64'(req_cyc[i] - t0), 64'(1 + i));
      end
      chk({tag, " wr_count"}, 64'(wr_cyc.size()), 64'(n));
      for (int i = 0; i < n && i < wr_cyc.size(); i++) begin
         ea = base + 22'(8 * i);
         chk({tag, " wr_word"}, wr_word[i], bank_word(ea));
         chk({tag, " wr_cycle"}, 64'(wr_cyc[i] - t0), 64'(2 + i + lat));
      end
      chk({tag, " done_count"}, 64'(done_cyc.size()), 64'd1);
      if (done_cyc.size() > 0)
         chk({tag, " done_cycle"}, 64'(done_cyc[0] - t0), 64'(exp_done - t0));
      chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_done - t0));
   endtask

   initial begin
      int t0;
      reset              = 1'b1;
      pcfg_start_pulse   = 1'b0;
      pcfg_start_addr    = '0;
      pcfg_num_cfgs      = '0;
      rdrs_rd_data       = '0;
      rdrs_rd_data_valid = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy",  64'(pcfg_busy), 64'd0);
      chk("rst done",  64'(pcfg_done_pulse), 64'd0);
      chk("rst rd_en", 64'(rdrq_rd_en), 64'd0);
      chk("rst wr_en", 64'(cgra_cfg_wr_en), 64'd0);
      chk("rst cfg",   {cgra_cfg_addr, cgra_cfg_data}, 64'd0);
      reset = 1'b0;
      step();
      chk("idle busy", 64'(pcfg_busy), 64'd0);

      // Basic transfer with fixed words
      bank[22'h100] = 64'h00010000_000000AA;
      bank[22'h108] = 64'h00010004_000000BB;
      bank[22'h110] = 64'h00010008_000000CC;
      run_xfer(22'h100, 3, 2, 0, "basic");
      if (wr_word.size() == 3) begin
         chk("basic wr0", wr_word[0], 64'h00010000_000000AA);
         chk("basic wr1", wr_word[1], 64'h00010004_000000BB);
         chk("basic wr2", wr_word[2], 64'h00010008_000000CC);
      end

      // Zero configurations
      run_xfer(22'h500, 0, 2, 0, "zero");

      // Alignment and wrap-around
      run_xfer(22'h3FFFFB, 2, 2, 0, "wrap");
      if (req_addr.size() == 2) begin
         chk("wrap addr0", 64'(req_addr[0]), 64'h3FFFF8);
         chk("wrap addr1", 64'(req_addr[1]), 64'h0);
      end

      // Start while busy is ignored
      run_xfer(22'h800, 4, 2, 2, "busy_start");

      // Idle response is dropped
      clear_logs();
      rdrs_rd_data_valid = 1'b1;
      rdrs_rd_data       = {$urandom, $urandom};
      repeat (3) step();
      chk("idle_rsp wr_count", 64'(wr_cyc.size()), 64'd0);
`ifdef GLB_PCFG_DMA_ERR_EN
      chk("err set", 64'(pcfg_err), 64'd1);
      repeat (3) step();
      chk("err held", 64'(pcfg_err), 64'd1);
      run_xfer(22'h1230, 2, 3, 0, "err_clear");
      chk("err cleared", 64'(pcfg_err), 64'd0);
`endif

      // Reset after 2 of 6 requests; 2 responses arrive after reset
      g_lat = 3;
      clear_logs();
      pcfg_start_addr  = 22'h2000;
      pcfg_num_cfgs    = 16'd6;
      pcfg_start_pulse = 1'b1;
      t0 = cyc;
      step();
      step();
      chk("rstmid reqs_before", 64'(req_cyc.size()), 64'd2);
      reset = 1'b1;
      #1;
      chk("rstmid busy",    64'(pcfg_busy), 64'd0);
      chk("rstmid rd_en",   64'(rdrq_rd_en), 64'd0);
      chk("rstmid rd_addr", 64'(rdrq_rd_addr), 64'd0);
      chk("rstmid wr_en",   64'(cgra_cfg_wr_en), 64'd0);
      chk("rstmid cfg",     {cgra_cfg_addr, cgra_cfg_data}, 64'd0);
      chk("rstmid cfg_rd",  64'(cgra_cfg_rd_en), 64'd0);
      step();
      reset = 1'b0;
      repeat (8) step();
      chk("rstmid reqs_after", 64'(req_cyc.size()), 64'd2);
      chk("rstmid writes",     64'(wr_cyc.size()), 64'd0);
      chk("rstmid dones",      64'(done_cyc.size()), 64'd0);
      chk("rstmid drained",    64'(pend.size()), 64'd0);
      chk("rstmid t0_used",    64'(cyc - t0), 64'd11);
      run_xfer(22'h2000, 3, 1, 0, "post_reset");

      // Randomized transfers
      for (int r = 0; r < 6; r++) begin
         run_xfer(22'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(1, 5)), 0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
